// File: rtl/cdr_phase_tracker.sv
// cdr_phase_tracker
//   Digital clock-and-data-recovery phase tracker for the USB2 receive path.
//   Each cycle the multi-phase oversampling front end delivers one bit per
//   sampling phase. The tracker locates the data edge among those phases,
//   filters phase-error votes, steers the sampling phase and emits 0, 1 or 2
//   recovered bits per cycle (DROP / ADD when the phase wraps around).
//
// Parameters
//   PHASES   : sampling phases per clock period (>= 3)
//   FILT_TH  : net votes required to step the sampling phase (>= 1)
//   LOCK_CNT : consecutive good edges required to assert locked (>= 1)
//
// Ports
//   clock     in   receive clock
//   reset     in   asynchronous, active-high reset
//   samples   in   [PHASES-1:0] phase samples, bit 0 is the earliest phase
//   data_out  out  [1:0] recovered bits, bit 0 goes first on the line
//   data_cnt  out  [1:0] number of valid bits in data_out (0, 1 or 2)
//   add       out  pulse, coincident with data_cnt = 2
//   drop      out  pulse, coincident with data_cnt = 0
//   phase_sel out  [PW-1:0] current sampling phase
//   locked    out  tracker locked
//
// Configuration macro
//   CDR_LOCK_DETECT_EN : builds the good-edge counter that drives locked.
//                        When undefined, locked is tied to 1'b1.

module cdr_phase_tracker #(
  parameter  int PHASES   = 5,
  parameter  int FILT_TH  = 4,
  parameter  int LOCK_CNT = 8,
  localparam int PW       = $clog2(PHASES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PHASES-1:0] samples,
  output logic [1:0]        data_out,
  output logic [1:0]        data_cnt,
  output logic              add,
  output logic              drop,
  output logic [PW-1:0]     phase_sel,
  output logic              locked
);

  localparam int HALF = PHASES / 2;
  localparam int EW   = PW + 2;                  // signed phase-error width
  localparam int VW   = $clog2(FILT_TH + 1) + 1; // signed vote-counter width
  localparam int CW   = PW + 1;                  // transition-count width
  localparam bit EVEN = ((PHASES % 2) == 0);

  localparam logic [PW-1:0]        PH_MAX = PW'(PHASES - 1);
  localparam logic [PW-1:0]        PH_RST = PW'(HALF);
  localparam logic [PW-1:0]        PH_ONE = PW'(1);
  localparam logic [CW-1:0]        CNT_ONE = CW'(1);
  localparam logic [PW:0]          HALF_U = (PW + 1)'(HALF);
  localparam logic [PW:0]          PH_U   = (PW + 1)'(PHASES);
  localparam logic signed [EW-1:0] HALF_S = EW'(HALF);
  localparam logic signed [EW-1:0] PH_S   = EW'(PHASES);
  localparam logic signed [VW-1:0] TH_S   = VW'(FILT_TH);
  localparam logic signed [VW-1:0] V_ONE  = VW'(1);

  // State
  logic                 prev_last_r;   // last phase sample of the previous cycle
  logic [PW-1:0]        phase_sel_r;
  logic signed [VW-1:0] vote_r;
  logic                 wrap_up_r;     // last step went PHASES-1 -> 0
  logic                 wrap_dn_r;     // last step went 0 -> PHASES-1
  logic [1:0]           data_out_r;
  logic [1:0]           data_cnt_r;
  logic                 add_r;
  logic                 drop_r;

  // Combinational
  logic [PHASES:0]      x_s;
  logic [PHASES-1:0]    trans_s;
  logic [CW-1:0]        tcnt_s;
  logic [PW-1:0]        edge_pos_s;
  logic                 edge_valid_s;
  logic                 glitch_s;
  logic                 vote_en_s;
  logic [PW:0]          desired_sum_s;
  logic [PW-1:0]        desired_s;
  logic signed [EW-1:0] err_raw_s;
  logic signed [EW-1:0] err_s;
  logic                 err_pos_s;
  logic                 err_neg_s;
  logic signed [VW-1:0] vote_inc_s;
  logic signed [VW-1:0] vote_dec_s;
  logic signed [VW-1:0] vote_nxt_s;
  logic                 step_up_s;
  logic                 step_dn_s;
  logic [PW-1:0]        phase_nxt_s;
  logic                 wrap_up_nxt_s;
  logic                 wrap_dn_nxt_s;
  logic [1:0]           dout_nxt_s;
  logic [1:0]           cnt_nxt_s;
  logic                 add_nxt_s;
  logic                 drop_nxt_s;

  // Edge detection over the extended vector {samples, prev[PHASES-1]}
  always_comb begin
    x_s        = {samples, prev_last_r};
    trans_s    = x_s[PHASES:1] ^ x_s[PHASES-1:0];
    tcnt_s     = '0;
    edge_pos_s = '0;
    for (int i = 0; i < PHASES; i++) begin
      if (trans_s[i]) begin
        tcnt_s     = tcnt_s + CNT_ONE;
        edge_pos_s = PW'(i);
      end else begin
        tcnt_s     = tcnt_s;
      end
    end
    edge_valid_s = (tcnt_s == CNT_ONE);
    glitch_s     = (tcnt_s > CNT_ONE);
    // A glitch never casts a vote
    vote_en_s    = edge_valid_s & ~glitch_s;
  end

  // Phase error: distance from the current phase to the eye centre, wrapped
  always_comb begin
    desired_sum_s = {1'b0, edge_pos_s} + HALF_U;
    if (desired_sum_s >= PH_U) begin
      desired_s = PW'(desired_sum_s - PH_U);
    end else begin
      desired_s = desired_sum_s[PW-1:0];
    end
    err_raw_s = $signed({2'b00, desired_s}) - $signed({2'b00, phase_sel_r});
    // Even PHASES: the half-way ambiguity resolves to +PHASES/2
    if (err_raw_s > HALF_S) begin
      err_s = err_raw_s - PH_S;
    end else if ((err_raw_s < -HALF_S) || (EVEN && (err_raw_s == -HALF_S))) begin
      err_s = err_raw_s + PH_S;
    end else begin
      err_s = err_raw_s;
    end
    err_neg_s = err_s[EW-1];
    err_pos_s = ~err_s[EW-1] && (err_s != '0);
  end

  // Vote filter and phase stepping (at most one step per cycle)
  always_comb begin
    vote_inc_s    = vote_r + V_ONE;
    vote_dec_s    = vote_r - V_ONE;
    vote_nxt_s    = vote_r;
    step_up_s     = 1'b0;
    step_dn_s     = 1'b0;
    if (vote_en_s && err_pos_s) begin
      if (vote_inc_s == TH_S) begin
        step_up_s  = 1'b1;
        vote_nxt_s = '0;
      end else begin
        vote_nxt_s = vote_inc_s;
      end
    end else if (vote_en_s && err_neg_s) begin
      if (vote_dec_s == -TH_S) begin
        step_dn_s  = 1'b1;
        vote_nxt_s = '0;
      end else begin
        vote_nxt_s = vote_dec_s;
      end
    end else begin
      vote_nxt_s = vote_r;
    end

    phase_nxt_s   = phase_sel_r;
    wrap_up_nxt_s = 1'b0;
    wrap_dn_nxt_s = 1'b0;
    if (step_up_s) begin
      if (phase_sel_r == PH_MAX) begin
        phase_nxt_s   = '0;
        wrap_up_nxt_s = 1'b1;
      end else begin
        phase_nxt_s   = phase_sel_r + PH_ONE;
      end
    end else if (step_dn_s) begin
      if (phase_sel_r == '0) begin
        phase_nxt_s   = PH_MAX;
        wrap_dn_nxt_s = 1'b1;
      end else begin
        phase_nxt_s   = phase_sel_r - PH_ONE;
      end
    end else begin
      phase_nxt_s = phase_sel_r;
    end
  end

  // Bit selection; a wrap in the previous cycle turns this cycle into DROP/ADD
  always_comb begin
    dout_nxt_s = 2'b00;
    cnt_nxt_s  = 2'd1;
    add_nxt_s  = 1'b0;
    drop_nxt_s = 1'b0;
    if (wrap_up_r) begin
      // The new phase re-samples the bit already delivered
      cnt_nxt_s  = 2'd0;
      drop_nxt_s = 1'b1;
    end else if (wrap_dn_r) begin
      // The skipped bit sat in the last phase of the previous cycle
      dout_nxt_s = {samples[PHASES-1], prev_last_r};
      cnt_nxt_s  = 2'd2;
      add_nxt_s  = 1'b1;
    end else begin
      dout_nxt_s = {1'b0, samples[phase_sel_r]};
    end
  end

  // Tracker state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_last_r <= 1'b0;
      phase_sel_r <= PH_RST;
      vote_r      <= '0;
      wrap_up_r   <= 1'b0;
      wrap_dn_r   <= 1'b0;
      data_out_r  <= 2'b00;
      data_cnt_r  <= 2'd0;
      add_r       <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      prev_last_r <= samples[PHASES-1];
      phase_sel_r <= phase_nxt_s;
      vote_r      <= vote_nxt_s;
      wrap_up_r   <= wrap_up_nxt_s;
      wrap_dn_r   <= wrap_dn_nxt_s;
      data_out_r  <= dout_nxt_s;
      data_cnt_r  <= cnt_nxt_s;
      add_r       <= add_nxt_s;
      drop_r      <= drop_nxt_s;
    end
  end

  assign data_out  = data_out_r;
  assign data_cnt  = data_cnt_r;
  assign add       = add_r;
  assign drop      = drop_r;
  assign phase_sel = phase_sel_r;

`ifdef CDR_LOCK_DETECT_EN
  localparam int            LW       = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
  localparam logic [LW-1:0] LOCK_ONE = LW'(1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  logic [LW-1:0] lock_cnt_r;
  logic [LW-1:0] lock_nxt_s;
  logic          locked_r;
  logic          small_err_s;

  // Good-edge counting: saturates, cleared by glitches and large errors
  always_comb begin
    small_err_s = (err_s == '0) || (err_s == E_ONE) || (err_s == -E_ONE);
    if (glitch_s || (edge_valid_s && !small_err_s)) begin
      lock_nxt_s = '0;
    end else if (edge_valid_s && (lock_cnt_r != LOCK_MAX)) begin
      lock_nxt_s = lock_cnt_r + LOCK_ONE;
    end else begin
      lock_nxt_s = lock_cnt_r;
    end
  end

  // Lock counter and registered lock flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_cnt_r <= '0;
      locked_r   <= 1'b0;
    end else begin
      lock_cnt_r <= lock_nxt_s;
      locked_r   <= (lock_nxt_s == LOCK_MAX);
    end
  end

  assign locked = locked_r;
`else
  assign locked = 1'b1;
`endif

endmodule

// File: tb/tb_cdr_phase_tracker.sv
`timescale 1ns/1ps
module tb_cdr_phase_tracker;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] samples = 5'b00000;
  logic [1:0] data_out;
  logic [1:0] data_cnt;
  logic       add;
  logic       drop;
  logic [2:0] phase_sel;
  logic       locked;

  typedef struct packed {
    logic [1:0] dout;
    logic [1:0] cnt;
    logic       add;
    logic       drop;
    logic [2:0] ph;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  cdr_phase_tracker #(.PHASES(5), .FILT_TH(4), .LOCK_CNT(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .samples   (samples),
    .data_out  (data_out),
    .data_cnt  (data_cnt),
    .add       (add),
    .drop      (drop),
    .phase_sel (phase_sel),
    .locked    (locked)
  );

  always #5 clock = ~clock;

  function automatic logic lock_exp(input logic l);
`ifdef CDR_LOCK_DETECT_EN
    return l;
`else
    return l | 1'b1;
`endif
  endfunction

  task automatic check(input string name, input exp_t e);
    exp_t got;
    got = {data_out, data_cnt, add, drop, phase_sel, locked};
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s: got dout=%b cnt=%0d add=%b drop=%b ph=%0d lk=%b, expected dout=%b cnt=%0d add=%b drop=%b ph=%0d lk=%b",
               name, got.dout, got.cnt, got.add, got.drop, got.ph, got.lk,
               e.dout, e.cnt, e.add, e.drop, e.ph, e.lk);
    end
  endtask

  // Drive one sample word and queue the output expected after the next edge
  task automatic put(input logic [4:0] s, input logic [1:0] d, input logic [1:0] c,
                     input logic a, input logic dr, input logic [2:0] p, input logic l);
    exp_t e;
    samples = s;
    e.dout = d; e.cnt = c; e.add = a; e.drop = dr; e.ph = p; e.lk = lock_exp(l);
    exp_q.push_back(e);
  endtask

  task automatic vec(input logic [4:0] s, input logic [1:0] d, input logic [1:0] c,
                     input logic a, input logic dr, input logic [2:0] p, input logic l);
    @(negedge clock);
    put(s, d, c, a, dr, p, l);
  endtask

  // Normal single-bit cycle
  task automatic nrm(input logic [4:0] s, input logic b, input logic [2:0] p, input logic l);
    vec(s, {1'b0, b}, 2'd1, 1'b0, 1'b0, p, l);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one registered output per cycle, checked after the edge
  initial begin
    exp_t e;
    int   idx;
    idx = 0;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", idx), e);
        idx++;
      end
    end
  end

  initial begin
    exp_t rst_e;
    rst_e.dout = 2'b00; rst_e.cnt = 2'd0; rst_e.add = 1'b0; rst_e.drop = 1'b0;
    rst_e.ph = 3'd2; rst_e.lk = lock_exp(1'b0);

    #12;
    check("reset_initial", rst_e);

    // Centred stream: edge at 0, desired 2, no steps, lock on the 8th edge
    @(negedge clock);
    reset = 1'b0;
    put(5'b11111, 2'b01, 2'd1, 1'b0, 1'b0, 3'd2, 1'b0);
    nrm(5'b00000, 1'b0, 3'd2, 1'b0);
    nrm(5'b11111, 1'b1, 3'd2, 1'b0);
    nrm(5'b00000, 1'b0, 3'd2, 1'b0);
    nrm(5'b11111, 1'b1, 3'd2, 1'b0);
    nrm(5'b00000, 1'b0, 3'd2, 1'b0);
    nrm(5'b11111, 1'b1, 3'd2, 1'b0);
    nrm(5'b00000, 1'b0, 3'd2, 1'b1);

    // Glitch drops lock, then a no-edge cycle holds everything
    nrm(5'b01010, 1'b0, 3'd2, 1'b0);
    nrm(5'b00000, 1'b0, 3'd2, 1'b0);

    // Late drift: edge at 1, four +1 votes step 2 -> 3, then d = 0
    nrm(5'b11110, 1'b1, 3'd2, 1'b0);
    nrm(5'b00001, 1'b0, 3'd2, 1'b0);
    nrm(5'b11110, 1'b1, 3'd2, 1'b0);
    nrm(5'b00001, 1'b0, 3'd3, 1'b0);
    nrm(5'b11110, 1'b1, 3'd3, 1'b0);
    nrm(5'b00001, 1'b0, 3'd3, 1'b0);

    // Edge at 2: step 3 -> 4; lock re-acquired on the 8th good edge
    nrm(5'b11100, 1'b1, 3'd3, 1'b0);
    nrm(5'b00011, 1'b0, 3'd3, 1'b1);
    nrm(5'b11100, 1'b1, 3'd3, 1'b1);
    nrm(5'b00011, 1'b0, 3'd4, 1'b1);

    // DROP: edge at 3, desired 0, d = +1 from phase 4 -> wrap to 0
    nrm(5'b11000, 1'b1, 3'd4, 1'b1);
    nrm(5'b00111, 1'b0, 3'd4, 1'b1);
    nrm(5'b11000, 1'b1, 3'd4, 1'b1);
    nrm(5'b00111, 1'b0, 3'd0, 1'b1);
    vec(5'b11000, 2'b00, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1);
    nrm(5'b00111, 1'b1, 3'd0, 1'b1);

    // ADD: edge at 2, desired 4, d = -1 from phase 0 -> wrap to 4
    nrm(5'b11100, 1'b0, 3'd0, 1'b1);
    nrm(5'b00011, 1'b1, 3'd0, 1'b1);
    nrm(5'b11100, 1'b0, 3'd0, 1'b1);
    nrm(5'b00011, 1'b1, 3'd4, 1'b1);
    vec(5'b11100, 2'b10, 2'd2, 1'b1, 1'b0, 3'd4, 1'b1);
    nrm(5'b00011, 1'b0, 3'd4, 1'b1);

    // Edge at 4 from phase 4: |d| = 2 clears lock
    nrm(5'b10000, 1'b1, 3'd4, 1'b0);

    drain();

    // Asynchronous reset mid-clock
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("reset_midstream", rst_e);

    // First cycle after release is a normal single-bit cycle
    @(negedge clock);
    reset = 1'b0;
    put(5'b11111, 2'b01, 2'd1, 1'b0, 1'b0, 3'd2, 1'b0);

    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
